// File: rtl/generic_2clk_fifo_rd_drain_pkg.sv
// Shared types for the 2-clock FIFO read-side drain engine.
// Holds the control state encoding and output buffer sizing.
package generic_2clk_fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  // One slot per in-flight read plus one keeps 1 word/cycle
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/generic_2clk_fifo_rd_drain_if.sv
// Valid/ready output stream of the read-side drain engine.
// The master drives valid/data; the slave drives ready.
interface generic_2clk_fifo_rd_drain_if #(
  parameter int DAT_WIDTH = 32
);

  logic                 out_valid;
  logic [DAT_WIDTH-1:0] out_data;
  logic                 out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/generic_2clk_fifo_rd_drain_out_buf.sv
// Small circular buffer that absorbs RAM read latency.
// Head word is kept in a register so the stream data is glitch-free.
module generic_rd_out_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] wdata,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [DW-1:0] mem [DEPTH];
  ptr_t          head;
  ptr_t          tail;
  ptr_t          head_nx;
  ptr_t          tail_nx;
  logic [CW-1:0] cnt_nx;
  logic [DW-1:0] data_nx;
  logic          pop_ok;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign pop_ok = pop & (count != '0);

  always_comb begin
    head_nx = pop_ok ? inc(head) : head;
    tail_nx = push ? inc(tail) : tail;
    cnt_nx  = count + CW'(push) - CW'(pop_ok);
    // Word written this cycle may become the new head
    data_nx = (push && tail == head_nx) ? wdata : mem[head_nx];
    if (clear) begin
      head_nx = '0;
      tail_nx = '0;
      cnt_nx  = '0;
      data_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[tail] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      head      <= head_nx;
      tail      <= tail_nx;
      count     <= cnt_nx;
      head_data <= data_nx;
    end
  end

  ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_ok && !clear && count == CW'(DEPTH)));

endmodule

// File: rtl/generic_2clk_fifo_rd_drain.sv
// Read-side engine of the 2-clock FIFO: pops words, hides RAM latency,
// streams them out, and supports flush, counting and error capture.
module generic_2clk_fifo_rd_drain
  import generic_2clk_fifo_rd_pkg::*;
#(
  parameter int DAT_WIDTH = 32,
  parameter int RD_LAT    = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 rd_op,
  input  logic [DAT_WIDTH-1:0] rd_data,
  input  logic                 rd_empty,
  input  logic                 rd_empty_err,
  generic_2clk_fifo_rd_drain_if.master strm,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam int BUF_DEPTH = buf_depth(RD_LAT);
  localparam int BCW       = $clog2(BUF_DEPTH + 1);
  localparam int IFW       = $clog2(RD_LAT + 1);

  state_e               state;
  state_e               state_nx;
  logic [RD_LAT-1:0]    pipe;
  logic [IFW-1:0]       inflight;
  logic [BCW-1:0]       buf_cnt;
  logic [DAT_WIDTH-1:0] head;
  logic                 pop;
  logic                 push;
  logic                 clear;
  logic                 land;
  logic                 credit;

  assign land           = pipe[RD_LAT-1];
  assign strm.out_valid = (buf_cnt != '0);
  assign strm.out_data  = head;
  assign pop            = strm.out_valid & strm.out_ready;
  assign flush_busy     = (state == FLUSH);
  assign flush_done     = (state == DONE);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + IFW'(pipe[i]);
  end

  // Buffered plus in-flight words must never exceed the buffer
  assign credit = (int'(buf_cnt) + int'(inflight) - int'(pop))
                  < BUF_DEPTH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (flush_req)   state_nx = FLUSH;
        else if (enable) state_nx = RUN;
      RUN:
        if (flush_req)    state_nx = FLUSH;
        else if (!enable) state_nx = IDLE;
      FLUSH:
        if (rd_empty && inflight == '0) state_nx = DONE;
      DONE:
        state_nx = enable ? RUN : IDLE;
    endcase
  end

  always_comb begin
    rd_op = 1'b0;
    push  = 1'b0;
    clear = 1'b0;
    unique case (state)
      IDLE: begin
        push  = land;
        clear = flush_req;
      end
      RUN: begin
        rd_op = ~rd_empty & credit;
        push  = land;
        clear = flush_req;
      end
      FLUSH: rd_op = ~rd_empty;
      DONE: ;
    endcase
  end

  generic_rd_out_buf #(
    .DW    (DAT_WIDTH),
    .DEPTH (BUF_DEPTH),
    .CW    (BCW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .wdata     (rd_data),
    .count     (buf_cnt),
    .head_data (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe       <= '0;
      word_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      pipe     <= (pipe << 1) | RD_LAT'(rd_op);
      word_cnt <= word_cnt + CNT_WIDTH'(pop);
      if (rd_empty_err || (rd_op && rd_empty))
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_generic_2clk_fifo_rd_drain.sv
// Bench for the read-side drain engine: FIFO/RAM model, scoreboard,
// error vector table, directed corner sequences and random traffic.
module tb_generic_2clk_fifo_rd_drain;

  localparam int DW        = 32;
  localparam int RD_LAT    = 2;
  localparam int CW        = 8;
  localparam int BUF_DEPTH = RD_LAT + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable = 1'b0;
  logic          rd_op;
  logic [DW-1:0] rd_data = '0;
  logic          rd_empty = 1'b1;
  logic          rd_empty_err = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          flush_done;
  logic [CW-1:0] word_cnt;
  logic          err_sticky;
  logic          err_clr = 1'b0;

  generic_2clk_fifo_rd_drain_if #(.DAT_WIDTH(DW)) sif ();

  generic_2clk_fifo_rd_drain #(
    .DAT_WIDTH (DW),
    .RD_LAT    (RD_LAT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .rd_op        (rd_op),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .rd_empty_err (rd_empty_err),
    .strm         (sif),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done),
    .word_cnt     (word_cnt),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]     fifo_q[$];
  logic [DW-1:0]     exp_q[$];
  logic [DW-1:0]     lat[RD_LAT];
  logic [RD_LAT-1:0] lat_v;
  bit                m_busy;
  bit                m_done;
  int                m_cnt;
  bit                p_hold;
  logic [DW-1:0]     p_data;

  int cyc, op_cnt, first_op, last_op;
  int x_cnt, first_x, last_x, done_cnt;

  typedef struct {
    logic err;
    logic clr;
    logic exp;
  } evec_t;

  evec_t ev[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    op_cnt = 0; first_op = 0; last_op = 0;
    x_cnt = 0; first_x = 0; last_x = 0;
    done_cnt = 0;
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    lat_v    = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_cnt    = 0;
    p_hold   = 1'b0;
    rd_empty = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_op"}, 32'(rd_op), 0);
    chk({tag, "_valid"}, 32'(sif.out_valid), 0);
    chk({tag, "_data"}, sif.out_data, 0);
    chk({tag, "_busy"}, 32'(flush_busy), 0);
    chk({tag, "_done"}, 32'(flush_done), 0);
    chk({tag, "_cnt"}, 32'(word_cnt), 0);
    chk({tag, "_err"}, 32'(err_sticky), 0);
  endtask

  // One clock: check pre-edge outputs, then advance FIFO/RAM and reference
  task automatic cycle();
    logic          s_op, s_v, s_x, s_e, acc, nd;
    logic [DW-1:0] s_d, w;
    #1;
    s_op = rd_op;
    s_v  = sif.out_valid;
    s_x  = s_v & sif.out_ready;
    s_d  = sif.out_data;
    s_e  = rd_empty;
    chk("op_while_empty", 32'(s_op & s_e), 0);
    chk("flush_busy", 32'(flush_busy), 32'(m_busy));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt % 256));
    if (m_busy) chk("valid_in_flush", 32'(s_v), 0);
    if (p_hold) begin
      chk("hold_valid", 32'(s_v), 1);
      chk("hold_data", s_d, p_data);
    end
    if (s_x) begin
      chk("xfer_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("xfer_data", s_d, exp_q.pop_front());
      m_cnt++;
      if (x_cnt == 0) first_x = cyc;
      last_x = cyc;
      x_cnt++;
    end
    if (s_op) begin
      if (op_cnt == 0) first_op = cyc;
      last_op = cyc;
      op_cnt++;
    end
    if (flush_done) done_cnt++;
    acc    = flush_req && !m_busy && !m_done;
    nd     = m_busy && s_e && (lat_v == '0);
    p_hold = s_v && !sif.out_ready && !acc;
    p_data = s_d;
    @(posedge clk);
    #1;
    cyc++;
    w = $urandom;
    if (s_op && fifo_q.size() > 0) w = fifo_q.pop_front();
    for (int i = RD_LAT - 1; i > 0; i--) begin
      lat[i]   = lat[i-1];
      lat_v[i] = lat_v[i-1];
    end
    lat[0]   = w;
    lat_v[0] = s_op;
    rd_data  = lat[RD_LAT-1];
    rd_empty = (fifo_q.size() == 0);
    if (s_op && !m_busy && !acc) exp_q.push_back(w);
    if (acc) exp_q.delete();
    m_busy = acc || (m_busy && !nd);
    m_done = nd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    ev[0] = '{1'b0, 1'b0, 1'b0};
    ev[1] = '{1'b1, 1'b1, 1'b1};
    ev[2] = '{1'b0, 1'b0, 1'b1};
    ev[3] = '{1'b0, 1'b1, 1'b0};
    ev[4] = '{1'b0, 1'b0, 1'b0};
    ev[5] = '{1'b1, 1'b0, 1'b1};
    ev[6] = '{1'b0, 1'b1, 1'b0};

    sif.out_ready = 1'b0;
    cyc = 0;
    clr_log();
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: four preloaded words stream back-to-back
    sif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA000_0000 + i);
    cycle();
    enable = 1'b1;
    repeat (12) cycle();
    chk("t1_ops", op_cnt, 4);
    chk("t1_ops_span", last_op - first_op, 3);
    chk("t1_latency", first_x - first_op, RD_LAT + 1);
    chk("t1_xfers", x_cnt, 4);
    chk("t1_xfer_span", last_x - first_x, 3);
    chk("t1_cnt", 32'(word_cnt), 4);

    // 2: back-pressure stalls fetching at buffer depth
    clr_log();
    sif.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h2000_0000 + i);
    repeat (10) cycle();
    chk("t2_ops_stall", op_cnt, BUF_DEPTH);
    chk("t2_head_valid", 32'(sif.out_valid), 1);
    chk("t2_head_data", sif.out_data, 32'h2000_0000);
    sif.out_ready = 1'b1;
    repeat (20) cycle();
    chk("t2_ops", op_cnt, 8);
    chk("t2_xfers", x_cnt, 8);
    chk("t2_left", exp_q.size(), 0);

    // 3: flush with two buffered and five waiting in the FIFO
    sif.out_ready = 1'b0;
    fifo_q.push_back(32'h3000_0000);
    fifo_q.push_back(32'h3000_0001);
    repeat (8) cycle();
    enable = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'h3100_0000 + i);
    cycle();
    chk("t3_buffered", 32'(sif.out_valid), 1);
    c0 = m_cnt;
    clr_log();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    chk("t3_valid_off", 32'(sif.out_valid), 0);
    repeat (25) cycle();
    chk("t3_ops", op_cnt, 5);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_xfers", x_cnt, 0);
    chk("t3_cnt", 32'(word_cnt), 32'(c0 % 256));

    // 4: flush_req coinciding with a transfer
    enable = 1'b1;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'h4000_0000 + i);
    for (int i = 0; i < 20 && !sif.out_valid; i++) cycle();
    chk("t4_valid_seen", 32'(sif.out_valid), 1);
    c0 = m_cnt;
    clr_log();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    chk("t4_xfer", x_cnt, 1);
    chk("t4_cnt", 32'(word_cnt), 32'((c0 + 1) % 256));
    clr_log();
    repeat (25) cycle();
    chk("t4_none", x_cnt, 0);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_cnt_after", 32'(word_cnt), 32'((c0 + 1) % 256));

    // 5: sticky error table
    enable = 1'b0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_empty_err = ev[i].err;
      err_clr      = ev[i].clr;
      cycle();
      chk($sformatf("err_vec%0d", i), 32'(err_sticky), 32'(ev[i].exp));
    end
    rd_empty_err = 1'b0;
    err_clr      = 1'b0;

    // 6: asynchronous reset with words in flight
    enable = 1'b1;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'h6000_0000 + i);
    repeat (4) cycle();
    #3 reset_n = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    clr_log();
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'h6100_0000 + i);
    repeat (20) cycle();
    chk("t6_xfers", x_cnt, 4);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_cnt", 32'(word_cnt), 4);

    // 7: random traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      sif.out_ready = ($urandom_range(0, 9) < 7);
      flush_req     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1) == 1) fifo_q.push_back($urandom);
      cycle();
    end
    flush_req     = 1'b0;
    enable        = 1'b1;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 2000 &&
         (fifo_q.size() != 0 || exp_q.size() != 0 ||
          m_busy || m_done || lat_v != '0); i++)
      cycle();
    repeat (4) cycle();
    chk("rnd_drained", fifo_q.size() + exp_q.size(), 0);
    chk("rnd_cnt", 32'(word_cnt), 32'(m_cnt % 256));
    chk("rnd_err", 32'(err_sticky), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
